// File: rtl/pc_ctrl.sv
// pc_ctrl -- program counter / redirect controller for the fetch stage.
//
// Generates the fetch PC and the pipeline stall/flush controls. A redirect
// from execute reloads the PC and flushes if_id/id_ex; if the fetch bus is
// busy the redirect is parked in a pending register until it frees up.
// After an accepted redirect, flush_o stays high for FLUSH_CYCLES cycles in
// total: the redirect cycle itself plus FLUSH_CYCLES-1 cycles in FLUSH.
//
// Optional feature: define PC_MISALIGN_CHECK_EN to trap redirects whose
// target is not word aligned (sticky misalign_o, FSM parks in HALT until
// reset). Without it, target bits [1:0] are simply forced to zero.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   jump_en_i         redirect request from execute
//   jump_addr_i       redirect target
//   hold_flag_i       execute-stage hold (multi-cycle op)
//   ext_hold_i        fetch/bus not ready
//   pc_o              current fetch address (registered)
//   pc_valid_o        pc_o is a valid fetch address
//   stall_o           freeze PC, if_id, id_ex
//   flush_o           clear if_id, id_ex to NOP
//   misalign_o        misaligned redirect seen (sticky, checker builds only)
module pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        ext_hold_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {BOOT, RUN, FLUSH, PEND, HALT} state_e;

  // Counter preload: number of cycles spent in FLUSH after the redirect cycle.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
  // With a single flush cycle the redirect cycle already covers it.
  localparam state_e     POST_JMP = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_q;
  logic [3:0]  cnt_q;

  logic [31:0] tgt;
  logic        bad_run;   // live redirect target is misaligned
  logic        bad_pend;  // parked redirect target is misaligned

`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_q;

  assign tgt        = jump_addr_i;
  assign bad_run    = |jump_addr_i[1:0];
  assign bad_pend   = |pend_q[1:0];
  assign misalign_o = misalign_q;
`else
  logic unused_addr_lsb;

  assign tgt             = {jump_addr_i[31:2], 2'b00};
  assign bad_run         = 1'b0;
  assign bad_pend        = 1'b0;
  assign misalign_o      = 1'b0;
  assign unused_addr_lsb = ^jump_addr_i[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;

        RUN: begin
          if (jump_en_i) begin
            if (ext_hold_i) begin
              // Bus busy: park the target, load it when the bus frees up.
              pend_q  <= tgt;
              state_q <= PEND;
            end else if (bad_run) begin
`ifdef PC_MISALIGN_CHECK_EN
              misalign_q <= 1'b1;
`endif
              state_q <= HALT;
            end else begin
              pc_q    <= tgt;
              cnt_q   <= CNT_INIT;
              state_q <= POST_JMP;
            end
          end else if (!ext_hold_i && !hold_flag_i) begin
            pc_q <= pc_q + 32'd4;
          end
        end

        PEND: begin
          if (!ext_hold_i) begin
            if (bad_pend) begin
`ifdef PC_MISALIGN_CHECK_EN
              misalign_q <= 1'b1;
`endif
              state_q <= HALT;
            end else begin
              pc_q    <= pend_q;
              cnt_q   <= CNT_INIT;
              state_q <= POST_JMP;
            end
          end
        end

        FLUSH: begin
          if (!ext_hold_i) pc_q <= pc_q + 32'd4;
          // Counts cycles in FLUSH regardless of bus readiness.
          if (cnt_q <= 4'd1) begin
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        HALT: state_q <= HALT;

        default: state_q <= BOOT;
      endcase
    end
  end

  // flush/stall must react in the same cycle as the execute-stage request,
  // so they are decoded from the state plus the live inputs.
  always_comb begin
    pc_valid_o = 1'b0;
    stall_o    = 1'b0;
    flush_o    = 1'b0;
    case (state_q)
      RUN: begin
        pc_valid_o = 1'b1;
        flush_o    = jump_en_i;
        // A redirect without bus hold wins over hold_flag_i.
        stall_o    = ext_hold_i | (~jump_en_i & hold_flag_i);
      end
      FLUSH: begin
        pc_valid_o = 1'b1;
        flush_o    = 1'b1;
      end
      PEND, HALT: begin
        stall_o = 1'b1;
        flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_o = pc_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: two instances (FLUSH_CYCLES=1 with RESET_PC=0, and
// FLUSH_CYCLES=3 with RESET_PC=0x1000) share stimulus; each phase checks one.
module tb_pc_ctrl;

  localparam logic [31:0] RP1 = 32'h0000_0000;
  localparam logic [31:0] RP3 = 32'h0000_1000;

  // expected flag vector: {pc_valid, stall, flush, misalign}
  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_RUN  = 4'b1000;
  localparam logic [3:0] F_STL  = 4'b1100;
  localparam logic [3:0] F_JMP  = 4'b1010;
  localparam logic [3:0] F_JMPH = 4'b1110;
  localparam logic [3:0] F_PEND = 4'b0110;
  localparam logic [3:0] F_FL   = 4'b1010;
  localparam logic [3:0] F_HALT = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] addr = '0;
  logic        eh = 1'b0;
  logic        hf = 1'b0;

  logic [31:0] pc1, pc3;
  logic        v1, s1, f1, m1, v3, s3, f3, m3;

  pc_ctrl #(.RESET_PC(RP1), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(addr),
    .hold_flag_i(hf), .ext_hold_i(eh), .pc_o(pc1), .pc_valid_o(v1),
    .stall_o(s1), .flush_o(f1), .misalign_o(m1));

  pc_ctrl #(.RESET_PC(RP3), .FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(addr),
    .hold_flag_i(hf), .ext_hold_i(eh), .pc_o(pc3), .pc_valid_o(v3),
    .stall_o(s3), .flush_o(f3), .misalign_o(m3));

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int sel    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  flg;
  } exp_t;

  exp_t  sb[$];
  string tq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_pc();
    return (sel != 0) ? pc3 : pc1;
  endfunction

  function automatic logic [3:0] obs_flg();
    return (sel != 0) ? {v3, s3, f3, m3} : {v1, s1, f1, m1};
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, compare mid-cycle.
  task automatic step(input string tag, input logic j, input logic [31:0] a,
                      input logic e, input logic h,
                      input logic [31:0] xpc, input logic [3:0] xf);
    exp_t x;
    string t;
    jump_en = j; addr = a; eh = e; hf = h;
    sb.push_back('{xpc, xf});
    tq.push_back(tag);
    @(negedge clk);
    x = sb.pop_front();
    t = tq.pop_front();
    chk({t, "_pc"}, obs_pc(), x.pc);
    chk({t, "_flg"}, {28'd0, obs_flg()}, {28'd0, x.flg});
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag, input logic [31:0] xpc, input logic [3:0] xf);
    step(tag, 1'b0, 32'd0, 1'b0, 1'b0, xpc, xf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; jump_en = 1'b0; addr = '0; eh = 1'b0; hf = 1'b0;
    @(negedge clk);
    chk("rst_pc1", pc1, RP1);
    chk("rst_flg1", {28'd0, v1, s1, f1, m1}, 32'd0);
    chk("rst_pc3", pc3, RP3);
    chk("rst_flg3", {28'd0, v3, s3, f3, m3}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---------------- FLUSH_CYCLES=1 instance ----------------
    sel = 0;
    do_reset();
    idle("boot", RP1, F_IDLE);
    idle("run0", 32'h0, F_RUN);
    idle("run4", 32'h4, F_RUN);
    step("jmp100", 1, 32'h100, 0, 0, 32'h8, F_JMP);
    idle("tgt100", 32'h100, F_RUN);
    idle("seq104", 32'h104, F_RUN);
    for (int i = 0; i < 4; i++) step("hold", 0, 0, 0, 1, 32'h108, F_STL);
    idle("resume", 32'h108, F_RUN);
    idle("adv", 32'h10C, F_RUN);
    step("exthold", 0, 0, 1, 0, 32'h110, F_STL);
    idle("ehrel", 32'h110, F_RUN);
    // redirect while bus busy -> pending; jump/hold ignored while pending
    step("jmph", 1, 32'h200, 1, 0, 32'h114, F_JMPH);
    step("pend1", 1, 32'h300, 1, 1, 32'h114, F_PEND);
    step("pend2", 0, 0, 1, 0, 32'h114, F_PEND);
    step("pendrel", 0, 0, 0, 0, 32'h114, F_PEND);
    idle("tgt200", 32'h200, F_RUN);
    // jump wins over hold_flag
    step("jmpprio", 1, 32'h300, 0, 1, 32'h204, F_JMP);
    idle("tgt300", 32'h300, F_RUN);
    // wrap at top of address space
    step("jmpwrap", 1, 32'hFFFF_FFFC, 0, 0, 32'h304, F_JMP);
    idle("wrapA", 32'hFFFF_FFFC, F_RUN);
    idle("wrapB", 32'h0, F_RUN);
    // misaligned redirect
    step("jmp102", 1, 32'h102, 0, 0, 32'h4, F_JMP);
`ifdef PC_MISALIGN_CHECK_EN
    idle("halt1", 32'h4, F_HALT);
    step("halt2", 1, 32'h40, 0, 0, 32'h4, F_HALT);
    idle("halt3", 32'h4, F_HALT);
`else
    idle("mask", 32'h100, F_RUN);
    idle("maskseq", 32'h104, F_RUN);
`endif

    // asynchronous reset in the middle of PEND
    do_reset();
    idle("boot2", RP1, F_IDLE);
    idle("run0b", 32'h0, F_RUN);
    step("jmph2", 1, 32'h80, 1, 0, 32'h4, F_JMPH);
    step("pendA", 0, 0, 1, 0, 32'h4, F_PEND);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc1, RP1);
    chk("arst_flg", {28'd0, v1, s1, f1, m1}, 32'd0);
    @(posedge clk); #1;
    eh = 1'b0;
    rst_n = 1'b1;
    idle("boot3", RP1, F_IDLE);
    idle("run0c", 32'h0, F_RUN);
    idle("run4c", 32'h4, F_RUN);

    // ---------------- FLUSH_CYCLES=3 instance ----------------
    sel = 1;
    do_reset();
    idle("f3boot", RP3, F_IDLE);
    idle("f3run0", RP3, F_RUN);
    idle("f3run4", RP3 + 32'h4, F_RUN);
    step("f3jmp", 1, 32'h40, 0, 0, RP3 + 32'h8, F_JMP);
    step("f3fa", 1, 32'h80, 0, 1, 32'h40, F_FL);   // ignored in FLUSH
    idle("f3fb", 32'h44, F_FL);
    idle("f3run", 32'h48, F_RUN);
    idle("f3seq", 32'h4C, F_RUN);
    // pending redirect followed by the flush window
    step("f3jh", 1, 32'h60, 1, 0, 32'h50, F_JMPH);
    idle("f3prel", 32'h50, F_PEND);
    idle("f3pa", 32'h60, F_FL);
    idle("f3pb", 32'h64, F_FL);
    idle("f3pr", 32'h68, F_RUN);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
